// File: rtl/zports.sv
// ---------------------------------------------------------------------------
// zports -- ports-side configuration/status register file of the ZX-bus
// decoder.
//
// Captures Z80 port writes through a synchronized strobe and commits them to
// registers 1..3. Read data is served combinationally. Drives the ROM-window
// mapping and W5300 port-mode controls back into the bus decoder, stretches
// reset pulses for the W5300 and SL811, and merges their interrupt lines into
// one ZX-bus interrupt.
//
// Build option: define ZPORTS_INT_EN to build the interrupt logic. Without it,
// register 3 reads 0x00, writes to it are ignored and zint_n is tied high.
//
// Parameters:
//   RST_CTR_W      width of each chip reset counter; pulse = 2^RST_CTR_W-1 cycles
// Ports:
//   fclk           system clock
//   zrst_n         asynchronous active-low reset
//   ports_wrena    bus address selects the register window
//   ports_wrstb_n  asynchronous active-low write strobe (IORQ_n | WR_n)
//   ports_addr     register index (za[9:8])
//   ports_wrdata   raw Z80 write data
//   ports_rddata   combinational read data for ports_addr
//   rommap_win     16K window index for W5300 memory mapping
//   rommap_ena     memory mapping enable
//   w5300_ports    1: base-port low half to W5300, 0: to SL811
//   w5300_rst_n    W5300 hardware reset (registered, active-low)
//   sl811_rst_n    SL811 hardware reset (registered, active-low)
//   w5300_int_n    W5300 interrupt, active-low, asynchronous
//   sl811_intrq    SL811 interrupt, active-high, asynchronous
//   zint_n         ZX-bus interrupt request, registered, active-low
// ---------------------------------------------------------------------------
module zports #(
    parameter int RST_CTR_W = 8
) (
    input  logic       fclk,
    input  logic       zrst_n,
    input  logic       ports_wrena,
    input  logic       ports_wrstb_n,
    input  logic [1:0] ports_addr,
    input  logic [7:0] ports_wrdata,
    output logic [7:0] ports_rddata,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_ports,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    output logic       zint_n
);

    localparam logic [RST_CTR_W-1:0] CTR_ONES = '1;
    localparam logic [RST_CTR_W-1:0] CTR_ONE  = RST_CTR_W'(1);
    localparam logic [RST_CTR_W-1:0] CTR_ZERO = '0;

    // -----------------------------------------------------------------------
    // Write strobe capture
    // -----------------------------------------------------------------------
    logic       strb_s1, strb_s2, strb_s3;
    logic [2:0] sync_vld;   // fills with ones once s1..s3 hold real samples
    logic       idle_seen;  // strobe observed idle since reset
    logic       armed;
    logic       commit;
    logic       wr_fire;

    // The synchronizer is preset to the idle level, so right after reset its
    // "idle" is not a real observation. idle_seen waits until s2/s3 carry
    // sampled values and show the strobe high; a strobe already low when
    // reset is released is therefore never committed.
    assign commit  = ~strb_s2 & ~strb_s3 & armed & idle_seen;
    assign wr_fire = commit & ports_wrena;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others (the s1->s2->s3 chain would
    // collapse into a single flop with blocking assignments).
    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            strb_s1   <= 1'b1;
            strb_s2   <= 1'b1;
            strb_s3   <= 1'b1;
            sync_vld  <= 3'b000;
            idle_seen <= 1'b0;
            armed     <= 1'b1;
        end else begin
            strb_s1  <= ports_wrstb_n;
            strb_s2  <= strb_s1;
            strb_s3  <= strb_s2;
            sync_vld <= {sync_vld[1:0], 1'b1};
            if (sync_vld[2] && strb_s2 && strb_s3)
                idle_seen <= 1'b1;
            if (commit)
                armed <= 1'b0;
            else if (strb_s2 && strb_s3)
                armed <= 1'b1;
        end
    end

    logic wr_cfg, wr_rst;
    assign wr_cfg = wr_fire && (ports_addr == 2'd1);
    assign wr_rst = wr_fire && (ports_addr == 2'd2);

    // -----------------------------------------------------------------------
    // CONFIG register
    // -----------------------------------------------------------------------
    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            rommap_ena  <= 1'b0;
            rommap_win  <= 2'b00;
            w5300_ports <= 1'b0;
        end else if (wr_cfg) begin
            rommap_ena  <= ports_wrdata[0];
            rommap_win  <= ports_wrdata[2:1];
            w5300_ports <= ports_wrdata[4];
        end
    end

    // -----------------------------------------------------------------------
    // Chip reset pulse stretchers
    // -----------------------------------------------------------------------
    logic [RST_CTR_W-1:0] w_cnt, w_cnt_nx;
    logic [RST_CTR_W-1:0] s_cnt, s_cnt_nx;
    logic                 w_start, s_start;

    assign w_start = wr_rst & ports_wrdata[0];
    assign s_start = wr_rst & ports_wrdata[1];

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_cnt_nx = w_cnt;
        s_cnt_nx = s_cnt;
        if (w_start)
            w_cnt_nx = CTR_ONES;
        else if (w_cnt != CTR_ZERO)
            w_cnt_nx = w_cnt - CTR_ONE;
        if (s_start)
            s_cnt_nx = CTR_ONES;
        else if (s_cnt != CTR_ZERO)
            s_cnt_nx = s_cnt - CTR_ONE;
    end

    // rst_n is registered from the next counter value: a reload on the final
    // decrement keeps the next value nonzero, so the output never glitches.
    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            w_cnt       <= CTR_ONES;
            s_cnt       <= CTR_ONES;
            w5300_rst_n <= 1'b0;
            sl811_rst_n <= 1'b0;
        end else begin
            w_cnt       <= w_cnt_nx;
            s_cnt       <= s_cnt_nx;
            w5300_rst_n <= (w_cnt_nx == CTR_ZERO);
            sl811_rst_n <= (s_cnt_nx == CTR_ZERO);
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt aggregation
    // -----------------------------------------------------------------------
    logic [7:0] int_rddata;
    logic       unused_ok;

`ifdef ZPORTS_INT_EN
    logic       wi_s1, wi_s2, wi_s3;
    logic       si_s1, si_s2, si_s3;
    logic [1:0] pend, en;       // index 1: SL811, index 0: W5300
    logic [1:0] pend_set, pend_clr;
    logic       wr_int;

    assign wr_int   = wr_fire && (ports_addr == 2'd3);
    assign pend_set = {si_s2 & ~si_s3, wi_s3 & ~wi_s2};
    assign pend_clr = wr_int ? ports_wrdata[1:0] : 2'b00;

    always_ff @(posedge fclk or negedge zrst_n) begin
        if (!zrst_n) begin
            wi_s1  <= 1'b1;
            wi_s2  <= 1'b1;
            wi_s3  <= 1'b1;
            si_s1  <= 1'b0;
            si_s2  <= 1'b0;
            si_s3  <= 1'b0;
            pend   <= 2'b00;
            en     <= 2'b00;
            zint_n <= 1'b1;
        end else begin
            wi_s1  <= w5300_int_n;
            wi_s2  <= wi_s1;
            wi_s3  <= wi_s2;
            si_s1  <= sl811_intrq;
            si_s2  <= si_s1;
            si_s3  <= si_s2;
            // Set after clear: a new edge in the clearing cycle survives.
            pend   <= (pend & ~pend_clr) | pend_set;
            if (wr_int)
                en <= ports_wrdata[5:4];
            zint_n <= ~|(pend & en);
        end
    end

    assign int_rddata = {2'b00, en, 2'b00, pend};
    assign unused_ok  = &{1'b0, ports_wrdata};
`else
    assign int_rddata = 8'h00;
    assign zint_n     = 1'b1;
    assign unused_ok  = &{1'b0, ports_wrdata, w5300_int_n, sl811_intrq};
`endif

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        ports_rddata = 8'hFF;
        case (ports_addr)
            2'd0: ports_rddata = 8'hFF;
            2'd1: ports_rddata = {3'b000, w5300_ports, 1'b0, rommap_win, rommap_ena};
            2'd2: ports_rddata = {6'b000000, ~sl811_rst_n, ~w5300_rst_n};
            2'd3: ports_rddata = int_rddata;
            default: ports_rddata = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_zports.sv
// ---------------------------------------------------------------------------
// tb_zports -- self-checking bench for zports (RST_CTR_W = 8).
// Uses a small register model (CONFIG byte, interrupt enables) and counts
// reset-pulse lengths in cycles. Define ZPORTS_INT_EN for both files to
// exercise the interrupt build.
// ---------------------------------------------------------------------------
module tb_zports;

    localparam int W        = 8;
    localparam int PULSE    = (1 << W) - 1;

    logic       fclk = 1'b0;
    logic       zrst_n;
    logic       ports_wrena;
    logic       ports_wrstb_n;
    logic [1:0] ports_addr;
    logic [7:0] ports_wrdata;
    logic [7:0] ports_rddata;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_ports;
    logic       w5300_rst_n;
    logic       sl811_rst_n;
    logic       w5300_int_n;
    logic       sl811_intrq;
    logic       zint_n;

    zports #(.RST_CTR_W(W)) dut (
        .fclk          (fclk),
        .zrst_n        (zrst_n),
        .ports_wrena   (ports_wrena),
        .ports_wrstb_n (ports_wrstb_n),
        .ports_addr    (ports_addr),
        .ports_wrdata  (ports_wrdata),
        .ports_rddata  (ports_rddata),
        .rommap_win    (rommap_win),
        .rommap_ena    (rommap_ena),
        .w5300_ports   (w5300_ports),
        .w5300_rst_n   (w5300_rst_n),
        .sl811_rst_n   (sl811_rst_n),
        .w5300_int_n   (w5300_int_n),
        .sl811_intrq   (sl811_intrq),
        .zint_n        (zint_n)
    );

    always #5 fclk = ~fclk;

    int errors = 0;
    int checks = 0;

    // Register model
    logic [7:0] cfg_m;
    logic [1:0] en_m;

    typedef struct {
        logic       wrena;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp_cfg;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        ports_addr = a;
        #1;
        d = ports_rddata;
    endtask

    task automatic do_write(input logic we, input logic [1:0] a, input logic [7:0] d,
                            input int len);
        @(negedge fclk);
        ports_wrena   = we;
        ports_addr    = a;
        ports_wrdata  = d;
        ports_wrstb_n = 1'b0;
        repeat (len) @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (5) @(negedge fclk);
    endtask

    // Expected effect of a committed write on the register model.
    task automatic model_write(input logic we, input logic [1:0] a, input logic [7:0] d);
        if (we) begin
            if (a == 2'd1)
                cfg_m = d & 8'h17;
`ifdef ZPORTS_INT_EN
            if (a == 2'd3)
                en_m = d[5:4];
`endif
        end
    endtask

    task automatic check_cfg(input string tag);
        logic [7:0] d;
        rd(2'd1, d);
        check({tag, "_rd1"}, d, cfg_m);
        check({tag, "_outs"}, {4'b0, w5300_ports, rommap_win, rommap_ena},
              {4'b0, cfg_m[4], cfg_m[2:1], cfg_m[0]});
    endtask

    function automatic logic [7:0] exp_rd3();
`ifdef ZPORTS_INT_EN
        return {2'b00, en_m, 4'b0000};
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int n, wl, sl;

        vecs[0] = '{1'b1, 2'd1, 8'h15, 8'h15};
        vecs[1] = '{1'b0, 2'd1, 8'hFF, 8'h15};
        vecs[2] = '{1'b1, 2'd1, 8'hFF, 8'h17};
        vecs[3] = '{1'b1, 2'd0, 8'h00, 8'h17};
        vecs[4] = '{1'b1, 2'd1, 8'h0A, 8'h02};
        vecs[5] = '{1'b1, 2'd1, 8'hE9, 8'h01};
        vecs[6] = '{1'b1, 2'd1, 8'h00, 8'h00};

        zrst_n        = 1'b0;
        ports_wrena   = 1'b0;
        ports_wrstb_n = 1'b1;
        ports_addr    = 2'd0;
        ports_wrdata  = 8'h00;
        w5300_int_n   = 1'b1;
        sl811_intrq   = 1'b0;
        cfg_m         = 8'h00;
        en_m          = 2'b00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge fclk);
        check("rst_w5300_rst_n", 8'(w5300_rst_n), 8'h00);
        check("rst_sl811_rst_n", 8'(sl811_rst_n), 8'h00);
        check("rst_zint_n", 8'(zint_n), 8'h01);
        rd(2'd1, d); check("rst_cfg", d, 8'h00);
        rd(2'd2, d); check("rst_pulses", d, 8'h03);
        rd(2'd3, d); check("rst_int", d, 8'h00);

        // ---------------- power-on chip reset length ----------------
        @(negedge fclk);
        zrst_n = 1'b1;
        n = 0;
        while (!w5300_rst_n && n < 400) begin
            n++;
            @(negedge fclk);
        end
        check_int("por_len", n, PULSE);
        check("por_sl811_done", 8'(sl811_rst_n), 8'h01);
        check("por_zint_n", 8'(zint_n), 8'h01);
        rd(2'd0, d); check("rd0_ff", d, 8'hFF);

        // ---------------- write latency: 0x15 to CONFIG ----------------
        @(negedge fclk);
        ports_wrena   = 1'b1;
        ports_addr    = 2'd1;
        ports_wrdata  = 8'h15;
        ports_wrstb_n = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        check("lat_early", {4'b0, w5300_ports, rommap_win, rommap_ena}, 8'h00);
        repeat (2) @(posedge fclk);
        #1;
        check("lat_commit", {4'b0, w5300_ports, rommap_win, rommap_ena}, 8'h0D);
        repeat (4) @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (5) @(negedge fclk);
        cfg_m = 8'h15;
        check_cfg("w15");

        // ---------------- table-driven CONFIG vectors ----------------
        foreach (vecs[i]) begin
            do_write(vecs[i].wrena, vecs[i].addr, vecs[i].data, 6);
            rd(2'd1, d);
            check($sformatf("vec%0d_rd1", i), d, vecs[i].exp_cfg);
            check($sformatf("vec%0d_outs", i), {4'b0, w5300_ports, rommap_win, rommap_ena},
                  {4'b0, vecs[i].exp_cfg[4], vecs[i].exp_cfg[2:1], vecs[i].exp_cfg[0]});
            cfg_m = vecs[i].exp_cfg;
        end
        rd(2'd0, d); check("rd0_after_vec", d, 8'hFF);

        // ---------------- W5300 pulse restart: 100 + 255 cycles ----------------
        wl = 0;
        sl = 0;
        fork
            begin
                repeat (600) begin
                    @(negedge fclk);
                    if (!w5300_rst_n) wl++;
                    if (!sl811_rst_n) sl++;
                end
            end
            begin
                @(negedge fclk);
                ports_wrena   = 1'b1;
                ports_addr    = 2'd2;
                ports_wrdata  = 8'h01;
                ports_wrstb_n = 1'b0;
                repeat (8) @(negedge fclk);
                ports_wrstb_n = 1'b1;
                repeat (20) @(negedge fclk);
                rd(2'd2, d); check("pulse_rd2", d, 8'h01);
                repeat (72) @(negedge fclk);
                ports_addr    = 2'd2;
                ports_wrdata  = 8'h01;
                ports_wrstb_n = 1'b0;
                repeat (8) @(negedge fclk);
                ports_wrstb_n = 1'b1;
            end
        join
        check_int("pulse_w5300_len", wl, 100 + PULSE);
        check_int("pulse_sl811_len", sl, 0);
        rd(2'd2, d); check("pulse_done_rd2", d, 8'h00);

        // SL811 pulse only
        do_write(1'b1, 2'd2, 8'h02, 6);
        rd(2'd2, d); check("sl_pulse_rd2", d, 8'h02);
        repeat (300) @(negedge fclk);
        rd(2'd2, d); check("sl_pulse_done", d, 8'h00);

`ifdef ZPORTS_INT_EN
        // ---------------- interrupts ----------------
        do_write(1'b1, 2'd3, 8'h30, 6);
        en_m = 2'b11;
        rd(2'd3, d); check("int_en_rd3", d, 8'h30);
        @(negedge fclk);
        w5300_int_n = 1'b0;
        repeat (3) @(negedge fclk);
        check("int_early", 8'(zint_n), 8'h01);
        @(negedge fclk);
        check("int_zint_low", 8'(zint_n), 8'h00);
        w5300_int_n = 1'b1;
        rd(2'd3, d); check("int_pend_w", d, 8'h31);
        do_write(1'b1, 2'd3, 8'h31, 6);
        rd(2'd3, d); check("int_clr_rd3", d, 8'h30);
        check("int_clr_zint", 8'(zint_n), 8'h01);

        // clear coinciding with a new falling edge: set wins
        fork
            begin
                @(negedge fclk);
                ports_wrena   = 1'b1;
                ports_addr    = 2'd3;
                ports_wrdata  = 8'h31;
                ports_wrstb_n = 1'b0;
                repeat (8) @(negedge fclk);
                ports_wrstb_n = 1'b1;
                repeat (5) @(negedge fclk);
            end
            begin
                @(negedge fclk);
                @(negedge fclk);
                w5300_int_n = 1'b0;
                repeat (3) @(negedge fclk);
                w5300_int_n = 1'b1;
            end
        join
        rd(2'd3, d); check("int_set_wins", d, 8'h31);
        check("int_set_wins_zint", 8'(zint_n), 8'h00);

        // SL811 rising edge
        do_write(1'b1, 2'd3, 8'h33, 6);
        rd(2'd3, d); check("int_clr_all", d, 8'h30);
        @(negedge fclk);
        sl811_intrq = 1'b1;
        repeat (3) @(negedge fclk);
        sl811_intrq = 1'b0;
        repeat (3) @(negedge fclk);
        rd(2'd3, d); check("int_pend_sl", d, 8'h32);
        check("int_sl_zint", 8'(zint_n), 8'h00);
        do_write(1'b1, 2'd3, 8'h03, 6);
        en_m = 2'b00;
        rd(2'd3, d); check("int_off_rd3", d, 8'h00);
        check("int_off_zint", 8'(zint_n), 8'h01);
`else
        // ---------------- interrupts absent ----------------
        @(negedge fclk);
        w5300_int_n = 1'b0;
        sl811_intrq = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge fclk);
            if (k == 3) begin
                w5300_int_n = 1'b1;
                sl811_intrq = 1'b0;
            end
            check($sformatf("noint_zint%0d", k), 8'(zint_n), 8'h01);
        end
        do_write(1'b1, 2'd3, 8'h33, 6);
        rd(2'd3, d); check("noint_rd3", d, 8'h00);
`endif

        // ---------------- randomized writes vs. model ----------------
        for (int it = 0; it < 40; it++) begin
            logic       we;
            logic [1:0] a;
            logic [7:0] dat;
            int         r;
            r   = $urandom_range(0, 2);
            a   = (r == 2) ? 2'd3 : 2'(r);
            dat = 8'($urandom);
            we  = ($urandom_range(0, 3) != 0);
            do_write(we, a, dat, $urandom_range(4, 7));
            model_write(we, a, dat);
            check_cfg($sformatf("rnd%0d", it));
            rd(2'd3, d); check($sformatf("rnd%0d_rd3", it), d, exp_rd3());
            rd(2'd0, d); check($sformatf("rnd%0d_rd0", it), d, 8'hFF);
        end

        // ---------------- reset during a write ----------------
        @(negedge fclk);
        ports_wrena   = 1'b1;
        ports_addr    = 2'd1;
        ports_wrdata  = 8'h15;
        ports_wrstb_n = 1'b0;
        @(negedge fclk);
        zrst_n = 1'b0;
        repeat (2) @(negedge fclk);
        zrst_n = 1'b1;
        cfg_m  = 8'h00;
        en_m   = 2'b00;
        repeat (10) @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (5) @(negedge fclk);
        check_cfg("midrst");
        do_write(1'b1, 2'd1, 8'h11, 6);
        model_write(1'b1, 2'd1, 8'h11);
        check_cfg("after_midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
